// File: rtl/rs_seg_pipe_adder.sv
// rtl/rs_seg_pipe_adder.sv - segmented, pipelined wide add/subtract with a valid/ready stream.
// Each stage adds one SEG_WIDTH slice; higher operand slices ride along in skew registers.
module rs_seg_pipe_adder #(
  parameter int WIDTH     = 64,
  parameter int SEG_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             co,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG_WIDTH;

  generate
    if ((WIDTH % SEG_WIDTH) != 0 || SEG_WIDTH < 3) begin : g_param_err
      $error("rs_seg_pipe_adder: WIDTH must be a multiple of SEG_WIDTH and SEG_WIDTH >= 3");
    end
  endgenerate

  logic stall;
  logic ovf_q;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic [WIDTH-1:0]     a_src, b_src, s_src, s_next;
    logic                 c_src, v_src;
    logic [SEG_WIDTH-1:0] sum;
    logic                 cmsb, cout;
    logic                 a_msb, b_msb;
    logic [WIDTH-1:0]     s_q;
    logic                 c_q, v_q;

    if (k == 0) begin : g_first
      assign a_src = a;
      assign b_src = b ^ {WIDTH{bi}};
      assign s_src = '0;
      assign c_src = ci;
      assign v_src = in_valid;
    end else begin : g_next
      assign a_src = g_stage[k-1].g_skew.a_q;
      assign b_src = g_stage[k-1].g_skew.b_q;
      assign s_src = g_stage[k-1].s_q;
      assign c_src = g_stage[k-1].c_q;
      assign v_src = g_stage[k-1].v_q;
    end

    // Split off the slice MSB so the carry into it is visible for overflow detection.
    assign {cmsb, sum[SEG_WIDTH-2:0]} = {1'b0, a_src[k*SEG_WIDTH +: SEG_WIDTH-1]}
                                      + {1'b0, b_src[k*SEG_WIDTH +: SEG_WIDTH-1]}
                                      + {{(SEG_WIDTH-1){1'b0}}, c_src};
    assign a_msb            = a_src[k*SEG_WIDTH + SEG_WIDTH-1];
    assign b_msb            = b_src[k*SEG_WIDTH + SEG_WIDTH-1];
    assign sum[SEG_WIDTH-1] = a_msb ^ b_msb ^ cmsb;
    assign cout             = (a_msb & b_msb) | (cmsb & (a_msb ^ b_msb));

    always_comb begin
      s_next = s_src;
      s_next[k*SEG_WIDTH +: SEG_WIDTH] = sum;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= v_src;
        c_q <= cout;
        s_q <= s_next;
      end
    end

    if (k < NSEG-1) begin : g_skew
      logic [WIDTH-1:0] a_q, b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_src;
          b_q <= b_src;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (!stall) begin
      ovf_q <= g_stage[NSEG-1].cmsb ^ g_stage[NSEG-1].cout;
    end
  end

  assign out_valid = g_stage[NSEG-1].v_q;
  assign y         = g_stage[NSEG-1].s_q;
  assign co        = g_stage[NSEG-1].c_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rs_seg_pipe_adder.sv
// tb/tb_rs_seg_pipe_adder.sv - directed self-checking bench for rs_seg_pipe_adder.
module tb_rs_seg_pipe_adder;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, bi, ci, out_valid, out_ready, co, ovf;
  logic [W-1:0] a, b, y;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  rs_seg_pipe_adder #(.WIDTH(64), .SEG_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bi(bi), .ci(ci),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .co(co), .ovf(ovf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi,
                         input logic tci, input logic [W-1:0] ey, input logic eco,
                         input logic eovf, input string name);
    a = ta; b = tb; bi = tbi; ci = tci; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (2) tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: out_valid=%b want 0 three cycles after accept", name, out_valid);
    end
    tick;
    checks++;
    if ({out_valid, co, ovf, y} !== {1'b1, eco, eovf, ey}) begin
      errors++;
      $display("FAIL %s: got v=%b co=%b ovf=%b y=%h want v=1 co=%b ovf=%b y=%h",
               name, out_valid, co, ovf, y, eco, eovf, ey);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = '1; b = 64'd1; bi = 1'b0; ci = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({out_valid, co, ovf, y} !== {3'b000, {W{1'b0}}}) begin
        errors++;
        $display("FAIL reset_state[%0d]: got v=%b co=%b ovf=%b y=%h want all 0",
                 i, out_valid, co, ovf, y);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_carry_chain;
    run_one('1, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, "carry_all_segments");
  endtask

  task automatic test_subtract;
    run_one(64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub_5_7");
    run_one(64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0, "sub_7_5");
  endtask

  task automatic test_overflow;
    run_one(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000,
            1'b0, 1'b1, "ovf_pos");
    run_one(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0,
            1'b1, 1'b1, "ovf_neg");
  endtask

  task automatic test_back_to_back;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] held, got, want;
    logic [W-1:0] bb;
    logic [W:0]   sum;
    logic         eovf;
    int           nin, nout;
    bit           need_new;
    nin = 0; nout = 0; need_new = 1'b1; held = '0;
    for (int cyc = 0; cyc < 60 && nout < 10; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 9);
      if (nin < 10) begin
        if (need_new) begin
          a  = {$urandom, $urandom};
          b  = {$urandom, $urandom};
          bi = 1'($urandom_range(0, 1));
          ci = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checks++;
      if (in_ready !== !(cyc >= 6 && cyc <= 9)) begin
        errors++;
        $display("FAIL b2b_in_ready[%0d]: got %b want %b", cyc, in_ready, !(cyc >= 6 && cyc <= 9));
      end
      need_new = 1'b0;
      if (in_valid && in_ready) begin
        bb   = bi ? ~b : b;
        sum  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
        eovf = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
        exp_q.push_back({eovf, sum[W], sum[W-1:0]});
        nin++;
        need_new = 1'b1;
      end
      got = {ovf, co, y};
      if (cyc == 6) held = got;
      if (cyc >= 7 && cyc <= 9) begin
        checks++;
        if (out_valid !== 1'b1 || got !== held) begin
          errors++;
          $display("FAIL b2b_hold[%0d]: got v=%b %h want v=1 %h", cyc, out_valid, got, held);
        end
      end
      if (out_valid && out_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got %h want %h", nout, got, want);
        end
        nout++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (nout != 10) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want 10", nout);
    end
    tick;
  endtask

  task automatic test_reset_flush;
    int seen;
    rst = 1'b0; out_ready = 1'b1; bi = 1'b0; ci = 1'b0;
    in_valid = 1'b1; a = 64'd10; b = 64'd20;
    tick;
    a = 64'd30;
    tick;
    a = 64'd50; rst = 1'b1;
    tick;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, co, ovf, y} !== {4'b1000, {W{1'b0}}}) begin
      errors++;
      $display("FAIL flush_after_reset: got rdy=%b v=%b co=%b ovf=%b y=%h want rdy=1 rest 0",
               in_ready, out_valid, co, ovf, y);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_no_output: got %0d valid cycles want 0", seen);
    end
    run_one(64'd1, 64'd2, 1'b0, 1'b0, 64'd3, 1'b0, 1'b0, "post_reset_beat");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bi = 1'b0; ci = 1'b0;
    test_reset;
    test_carry_chain;
    test_subtract;
    test_overflow;
    tick;
    test_back_to_back;
    test_reset_flush;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
